dmem_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache on the CPU MEM-stage data port. It consumes the core's data-memory request (read/write address, write data, write strobe) and returns the load word plus `data_mem_hazard`, which stalls the pipeline while a request is outstanding. Misses and all stores go to a simple req/ack backing-memory bus.

---
 rtl/dmem_cache_pkg.sv | 5 +
 rtl/dmem_cache_line_array.sv | 46 ++++
 rtl/dmem_cache.sv | 128 ++++++++++++
 tb/tb_dmem_cache.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_cache_pkg.sv
// dmem_cache_pkg: shared FSM encoding and strobe width for the data cache.
package dmem_cache_pkg;
    typedef enum logic [1:0] {DMEM_IDLE, DMEM_REFILL, DMEM_WRITE} dmem_state_e;
    localparam int DMEM_STRB_W = 4;
endpackage

// File: rtl/dmem_cache_line_array.sv
// dmem_line_array: valid/tag/data storage with a combinational lookup and one byte-merging write port.
module dmem_line_array
    import dmem_cache_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int LINE_NUM        = 16
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst,
    input  logic [DATA_ADDR_WIDTH-1:0] addr,
    output logic                       hit,
    output logic [DATA_WIDTH-1:0]      rdata,
    input  logic                       wr_en,
    input  logic                       wr_fill,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic [DMEM_STRB_W-1:0]     wr_strb
);
    localparam int IW = $clog2(LINE_NUM);
    localparam int TW = DATA_ADDR_WIDTH - 2 - IW;
    logic [LINE_NUM-1:0]   valid;
    logic [TW-1:0]         tags [LINE_NUM];
    logic [DATA_WIDTH-1:0] data [LINE_NUM];
    logic [IW-1:0]         idx;
    logic [TW-1:0]         tag;
    assign idx   = addr[2 +: IW];
    assign tag   = addr[DATA_ADDR_WIDTH-1 -: TW];
    assign hit   = valid[idx] && (tags[idx] == tag);
    assign rdata = data[idx];
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst)
            valid <= '0;
        else if (wr_en && wr_fill)
            valid[idx] <= 1'b1;
    end
    // Tag and data need no reset: a line is only read through its valid bit.
    always_ff @(posedge cpu_clk) begin
        if (wr_en) begin
            if (wr_fill)
                tags[idx] <= tag;
            for (int b = 0; b < DMEM_STRB_W; b++)
                if (wr_strb[b])
                    data[idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end
endmodule

// File: rtl/dmem_cache.sv
// dmem_cache: direct-mapped write-through, no-write-allocate data cache with a req/ack backing bus.
// Define DMEM_CACHE_STATS_EN to add hit/miss/write counters.
module dmem_cache
    import dmem_cache_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32,
    parameter int LINE_NUM        = 16
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_raddr,
    input  logic                       cpu_data_mem_read,
    input  logic [DATA_ADDR_WIDTH-1:0] cpu_data_mem_waddr,
    input  logic [DATA_WIDTH-1:0]      cpu_data_mem_wdata,
    input  logic                       cpu_data_mem_write,
    input  logic [DMEM_STRB_W-1:0]     cpu_data_mem_write_strobe,
    output logic [DATA_WIDTH-1:0]      data_mem_rdata,
    output logic                       data_mem_hazard,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic [DMEM_STRB_W-1:0]     mem_wstrb,
    input  logic                       mem_ack,
`ifdef DMEM_CACHE_STATS_EN
    output logic [31:0]                stat_hits,
    output logic [31:0]                stat_misses,
    output logic [31:0]                stat_writes,
`endif
    input  logic [DATA_WIDTH-1:0]      mem_rdata
);
    dmem_state_e                state, next;
    logic [DATA_ADDR_WIDTH-1:0] req_addr;
    logic                       hit, wr_en, wr_fill;
    logic [DATA_WIDTH-1:0]      line_rdata, wr_data;
    logic [DMEM_STRB_W-1:0]     wr_strb;
    // Write wins over a simultaneous read; during a refill the held read address selects the line.
    assign req_addr = cpu_data_mem_write ? cpu_data_mem_waddr : cpu_data_mem_raddr;
    dmem_line_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DATA_ADDR_WIDTH(DATA_ADDR_WIDTH),
        .LINE_NUM(LINE_NUM)
    ) u_lines (
        .cpu_clk(cpu_clk),
        .cpu_rst(cpu_rst),
        .addr(req_addr),
        .hit(hit),
        .rdata(line_rdata),
        .wr_en(wr_en),
        .wr_fill(wr_fill),
        .wr_data(wr_data),
        .wr_strb(wr_strb)
    );
    always_comb begin
        next            = state;
        data_mem_hazard = 1'b0;
        data_mem_rdata  = '0;
        wr_en           = 1'b0;
        wr_fill         = 1'b0;
        wr_data         = cpu_data_mem_wdata;
        wr_strb         = cpu_data_mem_write_strobe;
        case (state)
            DMEM_IDLE: begin
                if (cpu_data_mem_write) begin
                    data_mem_hazard = 1'b1;
                    next            = DMEM_WRITE;
                    wr_en           = hit;
                end else if (cpu_data_mem_read) begin
                    data_mem_hazard = !hit;
                    data_mem_rdata  = hit ? line_rdata : '0;
                    next            = hit ? DMEM_IDLE : DMEM_REFILL;
                end
            end
            DMEM_REFILL: begin
                data_mem_hazard = !mem_ack;
                data_mem_rdata  = mem_ack ? mem_rdata : '0;
                wr_en           = mem_ack;
                wr_fill         = mem_ack;
                wr_data         = mem_rdata;
                wr_strb         = '1;
                next            = mem_ack ? DMEM_IDLE : DMEM_REFILL;
            end
            DMEM_WRITE: begin
                data_mem_hazard = !mem_ack;
                next            = mem_ack ? DMEM_IDLE : DMEM_WRITE;
            end
            default: next = DMEM_IDLE;
        endcase
    end
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state     <= DMEM_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            state <= next;
            if (state == DMEM_IDLE && next != DMEM_IDLE) begin
                mem_req   <= 1'b1;
                mem_we    <= next == DMEM_WRITE;
                mem_addr  <= {req_addr[DATA_ADDR_WIDTH-1:2], 2'b00};
                mem_wdata <= cpu_data_mem_wdata;
                mem_wstrb <= (next == DMEM_WRITE) ? cpu_data_mem_write_strobe : '0;
            end else if (state != DMEM_IDLE && mem_ack) begin
                mem_req <= 1'b0;
            end
        end
    end
`ifdef DMEM_CACHE_STATS_EN
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_writes <= '0;
        end else if (state == DMEM_IDLE) begin
            if (cpu_data_mem_read && !cpu_data_mem_write && hit)
                stat_hits <= stat_hits + 32'd1;
            if (next == DMEM_REFILL)
                stat_misses <= stat_misses + 32'd1;
            if (next == DMEM_WRITE)
                stat_writes <= stat_writes + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_cache.sv
// tb_dmem_cache: scoreboard bench for dmem_cache with a delayed-ack backing memory slave.
module tb_dmem_cache;
    logic        cpu_clk = 0;
    logic        cpu_rst = 1;
    logic [31:0] raddr = 0, waddr = 0, wdata = 0;
    logic        rd = 0, wr = 0;
    logic [3:0]  wstrb_in = 0;
    logic [31:0] data_mem_rdata;
    logic        data_mem_hazard;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 0;
    int          n_cmp = 0, n_err = 0;
    int          ack_delay = 3;
    int          req_cnt = 0;
    logic        last_we;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_wstrb;
    logic [31:0] ref_mem [256];
    logic [31:0] bus_mem [256];
    logic [31:0] exp_q [$];

    dmem_cache dut (
        .cpu_clk(cpu_clk),
        .cpu_rst(cpu_rst),
        .cpu_data_mem_raddr(raddr),
        .cpu_data_mem_read(rd),
        .cpu_data_mem_waddr(waddr),
        .cpu_data_mem_wdata(wdata),
        .cpu_data_mem_write(wr),
        .cpu_data_mem_write_strobe(wstrb_in),
        .data_mem_rdata(data_mem_rdata),
        .data_mem_hazard(data_mem_hazard),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Backing slave: acks ack_delay cycles after it first sees a request.
    initial begin
        bit pending = 0;
        int wait_n = 0;
        forever begin
            @(posedge cpu_clk);
            #1;
            if (mem_ack || !mem_req) begin
                mem_ack = 0;
                pending = 0;
            end else begin
                if (!pending) begin
                    pending = 1;
                    wait_n = ack_delay;
                    req_cnt++;
                    last_we = mem_we;
                    last_addr = mem_addr;
                    last_wdata = mem_wdata;
                    last_wstrb = mem_wstrb;
                end
                if (wait_n == 0) begin
                    mem_ack = 1;
                    if (mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (mem_wstrb[b]) bus_mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    end else
                        mem_rdata = bus_mem[mem_addr[9:2]];
                end else
                    wait_n--;
            end
        end
    end

    task automatic wait_release(output int stall);
        bit done = 0;
        stall = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge cpu_clk);
            if (!data_mem_hazard) begin
                done = 1;
                break;
            end
            stall++;
        end
        if (!done) check("hazard_timeout", 32'd1, 32'd0);
    endtask

    task automatic cpu_read(input logic [31:0] a, input int exp_stall);
        int stall, n0;
        exp_q.push_back(ref_mem[a[9:2]]);
        n0 = req_cnt;
        raddr = a;
        rd = 1;
        wait_release(stall);
        check("rd_data", data_mem_rdata, exp_q.pop_front());
        check("rd_stall", stall, exp_stall);
        check("rd_reqs", req_cnt - n0, (exp_stall > 0) ? 1 : 0);
        if (exp_stall > 0) begin
            check("rd_bus_we", {31'd0, last_we}, 32'd0);
            check("rd_bus_addr", last_addr, {a[31:2], 2'b00});
        end
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int stall, n0;
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
        n0 = req_cnt;
        rd = 0;
        waddr = a;
        wdata = d;
        wstrb_in = s;
        wr = 1;
        wait_release(stall);
        check("wr_stall", stall, 1 + ack_delay);
        check("wr_reqs", req_cnt - n0, 1);
        check("wr_bus_we", {31'd0, last_we}, 32'd1);
        check("wr_bus_addr", last_addr, {a[31:2], 2'b00});
        check("wr_bus_wdata", last_wdata, d);
        check("wr_bus_wstrb", {28'd0, last_wstrb}, {28'd0, s});
        @(posedge cpu_clk);
        #1;
        wr = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
            bus_mem[i] = ref_mem[i];
        end
        ref_mem[16] = 32'hDEAD_BEEF;
        bus_mem[16] = 32'hDEAD_BEEF;
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst_hazard", {31'd0, data_mem_hazard}, 32'd0);
        check("rst_rdata", data_mem_rdata, 32'd0);
        @(posedge cpu_clk);
        #1;
        cpu_rst = 0;
        // cold miss then hit, byte-merge store hit
        cpu_read(32'h40, 4);
        cpu_read(32'h40, 0);
        cpu_write(32'h40, 32'h0000_00AA, 4'b0001);
        check("merge_model", ref_mem[16], 32'hDEAD_BEAA);
        cpu_read(32'h40, 0);
        // store miss does not allocate
        cpu_write(32'h80, 32'h1234_5678, 4'b1111);
        cpu_read(32'h80, 4);
        // 0x40 and 0x80 share index 0
        cpu_read(32'h40, 4);
        cpu_read(32'h80, 4);
        cpu_read(32'h40, 4);
        // one-cycle ack, back-to-back hit without a bubble
        ack_delay = 1;
        cpu_read(32'h104, 2);
        cpu_read(32'h104, 0);
        cpu_write(32'h104, 32'hC3C3_0000, 4'b1100);
        cpu_read(32'h104, 0);
        // immediate ack in the first bus cycle
        ack_delay = 0;
        cpu_read(32'h208, 1);
        cpu_write(32'h20C, 32'h0000_7700, 4'b0010);
        cpu_read(32'h20C, 1);
        rd = 0;
        @(negedge cpu_clk);
        check("idle_rdata", data_mem_rdata, 32'd0);
        check("idle_hazard", {31'd0, data_mem_hazard}, 32'd0);
        // reset in the middle of a refill
        ack_delay = 5;
        @(posedge cpu_clk);
        #1;
        raddr = 32'h300;
        rd = 1;
        repeat (2) @(negedge cpu_clk);
        check("pre_rst_hazard", {31'd0, data_mem_hazard}, 32'd1);
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        #1;
        rd = 0;
        cpu_rst = 1;
        #1;
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_hazard", {31'd0, data_mem_hazard}, 32'd0);
        @(posedge cpu_clk);
        #1;
        cpu_rst = 0;
        ack_delay = 2;
        cpu_read(32'h40, 3);
        cpu_read(32'h40, 0);
        rd = 0;
        repeat (2) @(posedge cpu_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
